// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg : shared fetch-stage types, jump table and halt encoding
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int JUMP_LUT_DEPTH = 8;
  localparam int JUMP_LUT_BITS  = 12;
  localparam int JUMP_SEL_BITS  = $clog2(JUMP_LUT_DEPTH);

  // Must stay in step with the assembler's jump table.
  localparam logic [JUMP_LUT_BITS-1:0] JUMP_LUT [JUMP_LUT_DEPTH] = '{
    12'd12, 12'd32, 12'd100, 12'd40, 12'd200, 12'd1000, 12'd2048, 12'd4095
  };

  localparam logic [8:0] HALT_OPCODE = 9'h1FF;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_jump_lut.sv
// ---------------------------------------------------------------------------
// fetch_jump_lut : combinational branch-index to fetch-target lookup
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_jump_lut
  import fetch_pkg::*;
#(
  parameter int PC_BITS = 12
) (
  input  logic [JUMP_SEL_BITS-1:0] sel,
  output logic [PC_BITS-1:0]       target
);

  logic [JUMP_LUT_BITS-1:0] entry;

  assign entry = JUMP_LUT[sel];

  // Table entries are fixed width; fit them to the configured address width.
  generate
    if (PC_BITS >= JUMP_LUT_BITS) begin : g_extend
      assign target = PC_BITS'(entry);
    end else begin : g_truncate
      assign target = entry[PC_BITS-1:0];
    end
  endgenerate

endmodule : fetch_jump_lut

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit : program counter / fetch sequencer (IDLE, RUN, HALT)
// Optional macro FETCH_PERF_EN adds the instr_count performance counter.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                   PC_BITS  = 12,
  parameter logic [PC_BITS-1:0]   START_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     halt,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [JUMP_SEL_BITS-1:0] branch_sel,
  output logic [PC_BITS-1:0]       pc,
  output logic                     fetch_valid,
`ifdef FETCH_PERF_EN
  output logic [31:0]              instr_count,
`endif
  output logic                     done,
  output logic                     wrap_err
);

  fetch_state_e        state_q, state_d;
  logic [PC_BITS-1:0]  pc_q, pc_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                done_q, done_d;
  logic                wrap_err_q, wrap_err_d;
  logic [PC_BITS-1:0]  branch_target;
  logic                enter_run;

  fetch_jump_lut #(
    .PC_BITS (PC_BITS)
  ) u_jump_lut (
    .sel    (branch_sel),
    .target (branch_target)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    done_d     = done_q;
    wrap_err_d = wrap_err_q;
    enter_run  = 1'b0;

    case (state_q)
      IDLE: begin
        pc_d = START_PC;
        if (start) begin
          state_d   = RUN;
          enter_run = 1'b1;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = HALT;
          done_d  = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (branch_taken) begin
          pc_d = branch_target;
        end else if (&pc_q) begin
          // Incrementing off the top of memory is an error, never a wrap.
          state_d    = HALT;
          done_d     = 1'b1;
          wrap_err_d = 1'b1;
        end else begin
          pc_d = pc_q + PC_BITS'(1);
        end
      end
      HALT: begin
        if (start) begin
          state_d    = RUN;
          pc_d       = START_PC;
          done_d     = 1'b0;
          wrap_err_d = 1'b0;
          enter_run  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
      end
    endcase

    fetch_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= START_PC;
      fetch_valid_q <= 1'b0;
      done_q        <= 1'b0;
      wrap_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      done_q        <= done_d;
      wrap_err_q    <= wrap_err_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign done        = done_q;
  assign wrap_err    = wrap_err_q;

`ifdef FETCH_PERF_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (enter_run) begin
      count_d = '0;
    end else if (fetch_valid_q && !stall && (count_q != '1)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;
`else
  logic unused_enter_run;
  assign unused_enter_run = enter_run;
`endif

endmodule : fetch_pc_unit

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit : directed self-checking bench for fetch_pc_unit
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        halt;
  logic        stall;
  logic        branch_taken;
  logic [2:0]  branch_sel;
  logic [11:0] pc;
  logic        fetch_valid;
  logic        done;
  logic        wrap_err;
`ifdef FETCH_PERF_EN
  logic [31:0] instr_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .PC_BITS  (12),
    .START_PC (12'd0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .halt         (halt),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_sel   (branch_sel),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
`ifdef FETCH_PERF_EN
    .instr_count  (instr_count),
`endif
    .done         (done),
    .wrap_err     (wrap_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int exp_pc, input bit exp_fv,
                           input bit exp_done, input bit exp_werr);
    check({tag, ".pc"},   32'(pc),          32'(exp_pc));
    check({tag, ".fv"},   32'(fetch_valid), 32'(exp_fv));
    check({tag, ".done"}, 32'(done),        32'(exp_done));
    check({tag, ".werr"}, 32'(wrap_err),    32'(exp_werr));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_sel = 3'd0;

    tick(); tick();
    check_out("reset", 0, 0, 0, 0);
`ifdef FETCH_PERF_EN
    check("reset.cnt", instr_count, 32'd0);
`endif

    // Start pulse: pc 0 live, then 1,2,3
    reset_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check_out("start", 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq.pc", 32'(pc), 32'(i));
    end
    check("seq.done", 32'(done), 32'd0);

    tick(); tick();
    check("pre_stall.pc", 32'(pc), 32'd5);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.pc", 32'(pc), 32'd5);
    end
`ifdef FETCH_PERF_EN
    check("stall.cnt", instr_count, 32'd5);
`endif
    stall = 1'b0;
    tick();
    check("post_stall.pc", 32'(pc), 32'd6);
`ifdef FETCH_PERF_EN
    check("post_stall.cnt", instr_count, 32'd6);
`endif

    tick();
    check("pre_br.pc", 32'(pc), 32'd7);

    // Stall beats branch
    branch_taken = 1'b1; branch_sel = 3'd3; stall = 1'b1;
    tick();
    check("stall_br.pc", 32'(pc), 32'd7);
    stall = 1'b0;
    tick();
    check("branch.pc", 32'(pc), 32'd40);
    branch_taken = 1'b0;
    tick();
    check("after_br.pc", 32'(pc), 32'd41);

    branch_taken = 1'b1; branch_sel = 3'd0;
    tick();
    check("br12.pc", 32'(pc), 32'd12);

    // Halt beats branch
    halt = 1'b1; branch_sel = 3'd3;
    tick();
    halt = 1'b0;
    check_out("halt", 12, 0, 1, 0);
    stall = 1'b1;
    tick();
    check_out("halt_ign", 12, 0, 1, 0);
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    check("halt_hold.pc", 32'(pc), 32'd12);
`ifdef FETCH_PERF_EN
    check("halt.cnt", instr_count, 32'd11);
`endif

    // Restart, branch to the last address, then overrun
    start = 1'b1;
    tick();
    start = 1'b0;
    check_out("restart", 0, 1, 0, 0);
`ifdef FETCH_PERF_EN
    check("restart.cnt", instr_count, 32'd0);
`endif
    branch_taken = 1'b1; branch_sel = 3'd7;
    tick();
    branch_taken = 1'b0;
    check_out("br_last", 4095, 1, 0, 0);
    tick();
    check_out("wrap", 4095, 0, 1, 1);
    tick();
    check_out("wrap_hold", 4095, 0, 1, 1);

    start = 1'b1;
    tick();
    start = 1'b0;
    check_out("wrap_restart", 0, 1, 0, 0);

    for (int i = 0; i < 20; i++) tick();
    check("run20.pc", 32'(pc), 32'd20);

    // Reset mid-run overrides a concurrent start
    reset_n = 1'b0; start = 1'b1;
    tick();
    check_out("midreset", 0, 0, 0, 0);
    reset_n = 1'b1; start = 1'b0;
    tick();
    check_out("idle_after", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_pc_unit

`default_nettype wire
